// File: rtl/rgmii_tx_rate_adapter.sv
// rgmii_tx_rate_adapter: paces a byte stream onto RGMII ODDR inputs at 1000M, 100M or 10M from a single 125 MHz clock.
module rgmii_tx_rate_adapter (
    input  logic       tx_mac_aclk,
    input  logic       tx_mac_resetn,
    input  logic [1:0] inband_clock_speed,
    input  logic [7:0] tx_axis_rgmii_tdata,
    input  logic       tx_axis_rgmii_tvalid,
    output logic       tx_axis_rgmii_tready,
    output logic       rgmii_txc_rise,
    output logic       rgmii_txc_fall,
    output logic [3:0] rgmii_txd_rise,
    output logic [3:0] rgmii_txd_fall,
    output logic       rgmii_tx_ctl_rise,
    output logic       rgmii_tx_ctl_fall,
    output logic [1:0] speed_active
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;
    state_t     r_state, w_state_nx;
    logic [1:0] r_spd_meta, r_spd_sync, r_speed;
    logic [5:0] r_phase, w_phase_max;
    logic [7:0] r_byte;
    logic [3:0] w_nib;
    logic       r_en, w_gig, w_100, w_wrap, w_last, w_take, w_apply;

    // Byte slot state: idle, low nibble, high nibble (1000M bytes live only in S_LO).
    always_ff @(posedge tx_mac_aclk) begin
        if (!tx_mac_resetn) r_state <= S_IDLE;
        else                r_state <= w_state_nx;
    end

    // Speed decode, handshake, speed-change gating, next state and RGMII outputs.
    always_comb begin
        w_gig                = r_speed[1];
        w_100                = r_speed == 2'b01;
        w_phase_max          = w_gig ? 6'd0 : w_100 ? 6'd4 : 6'd49;
        w_wrap               = r_phase == w_phase_max;
        w_last               = w_gig || r_state == S_HI;
        tx_axis_rgmii_tready = r_en && w_wrap && (r_state == S_IDLE || w_last);
        w_take               = tx_axis_rgmii_tready && tx_axis_rgmii_tvalid;
        w_apply              = r_en && w_wrap && r_state == S_IDLE && !tx_axis_rgmii_tvalid
                               && r_spd_sync != r_speed;
        w_state_nx           = r_state;
        if (w_take)
            w_state_nx = S_LO;
        else if (w_wrap)
            w_state_nx = (r_state == S_LO && !w_gig) ? S_HI : S_IDLE;
        rgmii_txc_rise    = r_en && (w_gig || (w_100 ? r_phase <= 6'd2 : r_phase <= 6'd24));
        rgmii_txc_fall    = r_en && !w_gig && (w_100 ? r_phase <= 6'd1 : r_phase <= 6'd24);
        w_nib             = r_state == S_HI ? r_byte[7:4] : r_byte[3:0];
        rgmii_txd_rise    = r_state == S_IDLE ? 4'd0 : w_gig ? r_byte[3:0] : w_nib;
        rgmii_txd_fall    = r_state == S_IDLE ? 4'd0 : w_gig ? r_byte[7:4] : w_nib;
        rgmii_tx_ctl_rise = r_state != S_IDLE;
        rgmii_tx_ctl_fall = r_state != S_IDLE;
        speed_active      = r_speed;
    end

    // Speed synchronizer, phase counter, applied speed and byte holding register.
    always_ff @(posedge tx_mac_aclk) begin
        if (!tx_mac_resetn) begin
            r_spd_meta <= 2'b10;
            r_spd_sync <= 2'b10;
            r_speed    <= 2'b10;
            r_phase    <= 6'd0;
            r_byte     <= 8'd0;
            r_en       <= 1'b0;
        end else begin
            r_spd_meta <= inband_clock_speed;
            r_spd_sync <= r_spd_meta;
            r_en       <= 1'b1;
            r_phase    <= w_wrap ? 6'd0 : r_phase + 6'd1;
            if (w_apply) r_speed <= r_spd_sync;
            if (w_take)  r_byte  <= tx_axis_rgmii_tdata;
        end
    end
endmodule

// File: tb/tb_rgmii_tx_rate_adapter.sv
// tb_rgmii_tx_rate_adapter: random and directed traffic checked every cycle against a slot-queue model.
module tb_rgmii_tx_rate_adapter;
    logic       clk = 1'b0;
    logic       rstn, tvalid, tready, txc_r, txc_f, ctl_r, ctl_f;
    logic [1:0] spd_in, spd_act;
    logic [7:0] tdata;
    logic [3:0] txd_r, txd_f;

    always #4 clk = ~clk;

    rgmii_tx_rate_adapter dut (
        .tx_mac_aclk          (clk),
        .tx_mac_resetn        (rstn),
        .inband_clock_speed   (spd_in),
        .tx_axis_rgmii_tdata  (tdata),
        .tx_axis_rgmii_tvalid (tvalid),
        .tx_axis_rgmii_tready (tready),
        .rgmii_txc_rise       (txc_r),
        .rgmii_txc_fall       (txc_f),
        .rgmii_txd_rise       (txd_r),
        .rgmii_txd_fall       (txd_f),
        .rgmii_tx_ctl_rise    (ctl_r),
        .rgmii_tx_ctl_fall    (ctl_f),
        .speed_active         (spd_act)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_ctl, n_take;
    logic       m_en;
    logic [1:0] m_spd, m_s1, m_s2;
    int         m_ph;
    logic [7:0] m_q[$];
    logic [7:0] src[$];
    logic       d_rstn, d_hold;
    logic [1:0] d_spd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int period(input logic [1:0] s);
        return s[1] ? 1 : (s == 2'b01) ? 5 : 50;
    endfunction

    // One clock: compare outputs with the model, drive inputs, advance the model across the edge.
    task automatic tick();
        int         p;
        logic       wrap, e_rdy, e_rise, e_fall, take, apply;
        logic [7:0] e_d;
        p      = period(m_spd);
        wrap   = m_ph == p - 1;
        e_rdy  = m_en && wrap && m_q.size() <= 1;
        e_rise = m_en && (p == 1 || (p == 5 ? m_ph < 3 : m_ph < 25));
        e_fall = m_en && ((p == 5 && m_ph < 2) || (p == 50 && m_ph < 25));
        e_d    = m_q.size() != 0 ? m_q[0] : 8'h00;
        chk("tready", tready, e_rdy);
        chk("txc", {txc_r, txc_f}, {e_rise, e_fall});
        chk("txd", {txd_f, txd_r}, e_d);
        chk("ctl", {ctl_r, ctl_f}, {2{m_q.size() != 0}});
        chk("speed", spd_act, m_spd);
        n_ctl += ctl_r;
        rstn   = d_rstn;
        spd_in = d_spd;
        tvalid = !d_hold && src.size() != 0;
        tdata  = tvalid ? src[0] : 8'($urandom);
        take   = d_rstn && e_rdy && tvalid;
        if (!d_rstn) begin
            m_en = 1'b0; m_spd = 2'b10; m_s1 = 2'b10; m_s2 = 2'b10; m_ph = 0;
            m_q.delete();
        end else begin
            apply = m_en && wrap && m_q.size() == 0 && !tvalid && m_s2 != m_spd;
            if (m_q.size() != 0) void'(m_q.pop_front());
            if (take) begin
                if (p == 1) m_q.push_back(tdata);
                else for (int i = 0; i < 2 * p; i++)
                    m_q.push_back(i < p ? {2{tdata[3:0]}} : {2{tdata[7:4]}});
                void'(src.pop_front());
                n_take++;
            end
            m_ph = wrap ? 0 : m_ph + 1;
            if (apply) m_spd = m_s2;
            m_s2 = m_s1;
            m_s1 = spd_in;
            m_en = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && src.size() != 0; k++) tick();
        chk("drain_left", src.size(), 0);
    endtask

    initial begin
        rstn = 1'b0; tvalid = 1'b0; tdata = 8'h00; spd_in = 2'b10;
        d_rstn = 1'b0; d_hold = 1'b0; d_spd = 2'b10;
        m_en = 1'b0; m_spd = 2'b10; m_s1 = 2'b10; m_s2 = 2'b10; m_ph = 0;
        n_ctl = 0; n_take = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        repeat (2) tick();
        d_rstn = 1'b1;
        tick();
        chk("rel_rdy", tready, 1);
        chk("rel_txc", {txc_r, txc_f}, 2'b10);

        // 72-byte burst at 1000M
        n_ctl = 0; n_take = 0;
        repeat (7) src.push_back(8'h55);
        src.push_back(8'hD5);
        repeat (64) src.push_back(8'($urandom));
        drain(200);
        repeat (3) tick();
        chk("burst_ctl", n_ctl, 72);
        chk("burst_take", n_take, 72);

        // 3-cycle tvalid gap mid-stream at 1000M
        n_ctl = 0; n_take = 0;
        repeat (20) src.push_back(8'($urandom));
        repeat (8) tick();
        d_hold = 1'b1;
        repeat (3) tick();
        d_hold = 1'b0;
        drain(100);
        repeat (3) tick();
        chk("gap_ctl", n_ctl, 20);
        chk("gap_take", n_take, 20);

        // single byte at 100M
        d_spd = 2'b01;
        repeat (10) tick();
        chk("spd100", spd_act, 2'b01);
        n_ctl = 0; n_take = 0;
        src.push_back(8'hA3);
        drain(50);
        repeat (15) tick();
        chk("b100_ctl", n_ctl, 10);
        chk("b100_take", n_take, 1);

        // two back-to-back bytes at 10M
        d_spd = 2'b00;
        repeat (12) tick();
        chk("spd10", spd_act, 2'b00);
        n_ctl = 0;
        src.push_back(8'h12);
        src.push_back(8'h34);
        drain(400);
        repeat (120) tick();
        chk("b10_ctl", n_ctl, 200);

        // 1000M -> 100M requested mid-frame
        d_spd = 2'b10;
        repeat (60) tick();
        chk("spd1000", spd_act, 2'b10);
        repeat (30) src.push_back(8'($urandom));
        repeat (10) tick();
        d_spd = 2'b01;
        drain(100);
        chk("sw_defer", spd_act, 2'b10);
        repeat (20) tick();
        chk("sw_after", spd_act, 2'b01);

        // reset mid-byte at 100M
        repeat (3) src.push_back(8'($urandom));
        repeat (14) tick();
        d_rstn = 1'b0;
        tick();
        chk("rst_ctl", {ctl_r, ctl_f, txc_r, txc_f, tready}, 0);
        src.delete();
        tick();
        d_rstn = 1'b1;
        tick();
        chk("rst_rel_rdy", tready, 1);
        chk("rst_rel_txc", {txc_r, txc_f}, 2'b10);

        // randomized traffic, gaps, speed changes and resets
        for (int c = 0; c < 6000; c++) begin
            if (src.size() < 3 && $urandom_range(0, 3) == 0) src.push_back(8'($urandom));
            d_hold = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 299) == 0) d_spd = 2'($urandom);
            d_rstn = $urandom_range(0, 999) != 0;
            tick();
        end
        d_rstn = 1'b1;
        d_hold = 1'b0;
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rgmii_tx_rate_adapter.md
RGMII_TX_RATE_ADAPTER -- requirements
Module: rgmii_tx_rate_adapter

Parameters
REQ-001 The block SHALL have no parameters; all rate constants are fixed: 125 MHz clock, 1/5/50 cycles per RGMII clock period for 1000M/100M/10M.

Interface
REQ-002 tx_mac_aclk  in  1  single 125 MHz clock; all logic on its rising edge.
REQ-003 tx_mac_resetn  in  1  reset, synchronous, active-low.
REQ-004 inband_clock_speed  in  2  asynchronous speed select: 2'b10=1000M, 2'b01=100M, 2'b00=10M, 2'b11 treated as 1000M.
REQ-005 tx_axis_rgmii_tdata  in  8  frame byte from the MAC transmitter (preamble, SFD, data and FCS already inserted).
REQ-006 tx_axis_rgmii_tvalid  in  1  byte valid; low between frames (IFG).
REQ-007 tx_axis_rgmii_tready  out  1  byte accept.
REQ-008 rgmii_txc_rise / rgmii_txc_fall  out  1 each  TXC level for the rising and falling half of the next cycle (ODDR inputs).
REQ-009 rgmii_txd_rise / rgmii_txd_fall  out  4 each  TXD nibble per half-cycle.
REQ-010 rgmii_tx_ctl_rise / rgmii_tx_ctl_fall  out  1 each  TX_CTL per half-cycle.
REQ-011 speed_active  out  2  currently applied speed code.

Function
REQ-012 inband_clock_speed SHALL pass through a 2-flop synchronizer; both flops reset to 2'b10.
REQ-013 A 6-bit phase counter SHALL run continuously: 0 at 1000M, 0..4 at 100M, 0..49 at 10M; wrap = phase at its maximum value.
REQ-014 TXC: 1000M rise=1 fall=0; 100M phase 0-1 (1,1), phase 2 (1,0), phase 3-4 (0,0); 10M phase 0-24 (1,1), phase 25-49 (0,0); TXC SHALL toggle with no dependence on traffic.
REQ-015 Each byte SHALL occupy one cycle at 1000M, 10 cycles at 100M (low nibble then high nibble, 5 cycles each), and 100 cycles at 10M (50 cycles per nibble).
REQ-016 Nibble and byte boundaries SHALL coincide with phase 0 (TXC rising).
REQ-017 tx_axis_rgmii_tready SHALL be high only in a wrap cycle when no byte is in progress or the current byte is on its final nibble slot; at 1000M this is every cycle.
REQ-018 Transfer when tvalid && tready; an accepted byte SHALL appear on the outputs starting the next cycle (latency 1), enabling back-to-back bytes with no gap.
REQ-019 1000M data: txd_rise=byte[3:0], txd_fall=byte[7:4]; 10/100M: txd_rise=txd_fall=current nibble.
REQ-020 TX_CTL: rise=fall=1 while a byte is being driven (TX_ER is never asserted); 0 otherwise.
REQ-021 With tvalid low at a byte-accept opportunity, the block SHALL drive txd=0 and tx_ctl=0 from the next cycle until the next accepted byte.
REQ-022 A change of the synchronized speed SHALL apply only in a wrap cycle with no byte in progress and tvalid low; on applying, the phase counter restarts at 0 and speed_active updates on the same edge.
REQ-023 A speed change while a byte is in progress or tvalid is high SHALL be deferred; no byte is truncated, and no TXC period is shortened below the old-speed high or low time.
REQ-024 tdata SHALL be captured into a holding register on transfer; the upstream block may change tdata after the transfer.

Reset
REQ-025 With tx_mac_resetn low at a clock edge: tready=0, txd_*=0, tx_ctl_*=0, txc_rise=txc_fall=0, phase=0, speed_active=2'b10, no byte in progress.
REQ-026 The first cycle after reset release SHALL follow REQ-014 at 1000M; a reset mid-byte SHALL abandon the byte with no further tx_ctl assertion.

Verification
REQ-027 1000M, 72-byte burst 55x7,D5,... with tvalid continuous -> tready=1 every cycle; tx_ctl high for exactly 72 cycles; byte 0xD5 gives rise=5, fall=D.
REQ-028 100M, single byte 0xA3 -> tready once at phase 4; txd=3 for 5 cycles then A for 5 cycles; TXC high for 5 half-slots, low for 5.
REQ-029 10M, two back-to-back bytes 0x12, 0x34 -> nibbles 2,1,4,3 of 50 cycles each; tx_ctl high for 200 contiguous cycles.
REQ-030 Speed switch 1000M->100M mid-frame -> frame completes at 1000M; switch applies after the 2-flop sync, at idle; next TXC period is 5 cycles starting at phase 0.
REQ-031 Reset asserted mid-byte at 100M -> next cycle all outputs zero per REQ-025; after release, TXC is 1000M pattern and tready=1.
REQ-032 Upstream tvalid dropped for 3 cycles mid-stream at 1000M -> tx_ctl low for exactly those 3 cycles, txd=0; no byte duplicated or lost.
